// File: rtl/mips_pkg.sv
// Shared widths, FSM encoding and captured-request layout for the data-memory responder.
package mips_pkg;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;
endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one synchronous read/write port, per-byte write enables, no reset.
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              re,
    input  logic [BE_W-1:0]   wbe,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [BE_W-1:0][7:0] mem [DEPTH];

    // Read and write share one edge; non-blocking update gives read-old-data.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[addr];
        for (int i = 0; i < BE_W; i++)
            if (wbe[i])
                mem[addr][i] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable data-memory responder for the MEM stage.
// Optional address-fault reporting on the err port when DMEM_RESP_ERR_EN is defined.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    dmem_state_t       state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    dmem_req_t         cap;
    logic [WORD_W-1:0] rdata_q, arr_rdata, load_val;
    logic [AW-1:0]     arr_addr;
    logic [BE_W-1:0]   arr_wbe;
    logic              arr_re, fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cap     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == ST_IDLE && req)
                cap <= '{we: we, be: be, addr: addr, wdata: wdata};
            if (state == ST_RESP && !cap.we)
                rdata_q <= load_val;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: if (req) begin
                if (LAT == 4'd0) begin
                    state_nx = ST_RESP;
                end else begin
                    state_nx = ST_WAIT;
                    cnt_nx   = LAT;
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef DMEM_RESP_ERR_EN
    assign fault = (cap.addr[1:0] != 2'b00) || (cap.addr[WORD_W-1:AW+2] != '0);
    assign err   = (state == ST_RESP) && fault;
`else
    assign fault = 1'b0;
`endif

    // The read is launched on the edge entering RESP; with zero latency that is the
    // acceptance edge, so the live address is used while still in IDLE.
    assign arr_addr = (state == ST_IDLE) ? addr[AW+1:2] : cap.addr[AW+1:2];
    assign arr_re   = (state_nx == ST_RESP);
    assign arr_wbe  = (state == ST_RESP && cap.we && !fault) ? cap.be : '0;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .addr  (arr_addr),
        .re    (arr_re),
        .wbe   (arr_wbe),
        .wdata (cap.wdata),
        .rdata (arr_rdata)
    );

    assign load_val = fault ? '0 : arr_rdata;
    assign rdata    = (state == ST_RESP && !cap.we) ? load_val : rdata_q;
    assign ack      = (state == ST_RESP);
    assign busy     = (state != ST_IDLE);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[WORD_W-1:AW+2],
                                cap.addr[1:0], cap.addr[WORD_W-1:AW+2]};

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;
    import mips_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT_M = 2;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_m = 1'b0, req0 = 1'b0, req15 = 1'b0, we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata_m, rdata0, rdata15;
    logic        ack_m, ack0, ack15, busy_m, busy0, busy15;
`ifdef DMEM_RESP_ERR_EN
    logic        err_m, err0, err15;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_M)) u_m (
        .clk(clk), .rst(rst), .req(req_m), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata_m), .ack(ack_m), .busy(busy_m)
`ifdef DMEM_RESP_ERR_EN
        , .err(err_m)
`endif
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .busy(busy0)
`ifdef DMEM_RESP_ERR_EN
        , .err(err0)
`endif
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .req(req15), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata15), .ack(ack15), .busy(busy15)
`ifdef DMEM_RESP_ERR_EN
        , .err(err15)
`endif
    );

    int          n_chk = 0, n_err = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the LATENCY=2 instance; inputs are scrambled once captured.
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d);
        int          n, idx;
        logic        f;
        logic [31:0] exp_rd;
        f = 1'b0;
`ifdef DMEM_RESP_ERR_EN
        f = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`endif
        idx    = int'((a >> 2) % DEPTH);
        exp_rd = f ? 32'h0 : model[idx];
        @(negedge clk);
        req_m = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("busy_inflight", 32'(busy_m), 32'd1);
        end while (!ack_m && n < 40);
        chk("ack_latency", 32'(n), 32'(LAT_M + 1));
        if (!w) begin
            chk("load_rdata", rdata_m, exp_rd);
            last_rd = exp_rd;
        end
`ifdef DMEM_RESP_ERR_EN
        chk("err_flag", 32'(err_m), 32'(f));
`endif
        if (w && !f)
            for (int i = 0; i < 4; i++)
                if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        req_m = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(ack_m), 32'd0);
        chk("busy_idle", 32'(busy_m), 32'd0);
        chk("rdata_hold", rdata_m, last_rd);
    endtask

    // Hold req high on the LATENCY=0 or LATENCY=15 instance and time the acks.
    task automatic b2b(input int sel, input int lat, input int nacks);
        int   cyc, acks, prev;
        logic a;
        @(negedge clk);
        we = 1'b0; be = '0; addr = 32'h10;
        if (sel == 0) req0 = 1'b1; else req15 = 1'b1;
        cyc = 0; acks = 0; prev = 0;
        while (acks < nacks && cyc < (lat + 2) * nacks + 10) begin
            @(negedge clk);
            cyc++;
            a = (sel == 0) ? ack0 : ack15;
            if (a) begin
                if (acks == 0) chk("b2b_first", 32'(cyc), 32'(lat + 1));
                else           chk("b2b_gap", 32'(cyc - prev), 32'(lat + 2));
                prev = cyc;
                acks++;
            end
        end
        req0 = 1'b0; req15 = 1'b0;
        chk("b2b_acks", 32'(acks), 32'(nacks));
        @(negedge clk);
        chk("b2b_idle", 32'((sel == 0) ? busy0 : busy15), 32'd0);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_rdata", rdata_m, 32'h0);
`ifdef DMEM_RESP_ERR_EN
        chk("rst_err", 32'(err_m), 32'd0);
`endif
        rst = 1'b1;

        // Directed: first load, full/partial/empty stores, unaligned and out-of-range
        access(1'b0, 4'hF, 32'h10, 32'h0);
        access(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
        access(1'b0, 4'hF, 32'h20, 32'h0);
        chk("full_store", last_rd, 32'hDEADBEEF);
        access(1'b1, 4'b0001, 32'h20, 32'h000000AA);
        access(1'b0, 4'hF, 32'h20, 32'h0);
        chk("partial_store", last_rd, 32'hDEADBEAA);
        access(1'b1, 4'b0000, 32'h20, 32'h11223344);
        access(1'b0, 4'hF, 32'h20, 32'h0);
        chk("be0_store", last_rd, 32'hDEADBEAA);
        access(1'b0, 4'hF, 32'h22, 32'h0);
        access(1'b1, 4'hF, 32'(DEPTH * 4), 32'h55AA55AA);
        access(1'b0, 4'hF, 32'h0, 32'h0);

        // Reset during WAIT of a store must drop the write and the ack
        access(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        req_m = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'h12345678;
        @(negedge clk);
        chk("mid_wait_busy", 32'(busy_m), 32'd1);
        rst = 1'b0; req_m = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_m), 32'd0);
        chk("mid_rst_rdata", rdata_m, 32'h0);
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_m) acks++;
        end
        chk("no_ack_after_rst", 32'(acks), 32'd0);
        access(1'b0, 4'hF, 32'h30, 32'h0);
        chk("aborted_store", last_rd, 32'hCAFEF00D);

        // Back-to-back throughput
        b2b(0, 0, 4);
        b2b(1, 15, 2);

        // Random traffic, including wrap-around and misaligned addresses
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'($urandom), 4'($urandom), 32'($urandom_range(0, DEPTH * 8 - 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, the wait cycles inserted before the response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port req  input  1  access request from the pipeline MEM stage; held high until ack.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 SHALL have port be  input  4  byte enables for stores; be[i] selects wdata[8i+7:8i].
REQ-008 SHALL have port addr  input  32  byte address; sampled with req.
REQ-009 SHALL have port wdata  input  32  store data; sampled with req.
REQ-010 SHALL have port rdata  output  32  load data; valid in the ack cycle and held until the next load ack.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high while a request is in flight; the pipeline uses it as a stall.
REQ-013 SHALL have port err  output  1  address-fault flag; present only when DMEM_RESP_ERR_EN is defined.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 In IDLE with req=1, SHALL capture we/be/addr/wdata at that edge.
- LATENCY>0: go to WAIT, wait counter loaded with LATENCY.
- LATENCY=0: go directly to RESP.
REQ-016 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter reaches 1.
REQ-017 ack SHALL be high for exactly one cycle, LATENCY+1 cycles after the cycle in which req was sampled.
REQ-018 In the RESP cycle, SHALL either write the captured bytes selected by be, or drive rdata with the addressed word; it then returns to IDLE.
REQ-019 A load SHALL return the memory contents as they were before any write in that same cycle; a store is visible to every later load.
REQ-020 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-021 Changes to req/we/be/addr/wdata while busy SHALL be ignored; the captured values govern the access.
REQ-022 req still high in the cycle after ack SHALL be treated as a new request accepted from IDLE (back-to-back throughput: one access per LATENCY+2 cycles).
REQ-023 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] and upper address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-024 A store with be=4'b0000 SHALL complete with ack and leave memory unchanged.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, counter 0, ack=0, busy=0, rdata=32'h0, err=0.
REQ-026 Reset asserted mid-access SHALL abort the access: no write occurs and no ack is produced after reset releases.
REQ-027 Memory array contents SHALL NOT be reset.

Configuration
REQ-028 With DMEM_RESP_ERR_EN defined, SHALL check the captured access for faults:
- a fault is addr[1:0]!=0 on any access, or addr >= DEPTH*4;
- on a fault, err=1 in the ack cycle, no memory write, and rdata=32'h0 for loads;
- err is otherwise 0.
REQ-029 Without DMEM_RESP_ERR_EN, SHALL omit the err port and its logic entirely; behaviour follows REQ-023.

Structure
REQ-030 SHALL take the word width (32), the byte-enable width (4) and the FSM state encoding from the shared package mips_pkg.
REQ-031 SHALL place the storage in one sub-module, dmem_array:
- one synchronous read/write port;
- per-byte write enables;
- no reset.

Verification
REQ-032 Reset then load: rst low 2 cycles, then high; LATENCY=2, load addr=0x10 -> ack in cycle 3 after acceptance, rdata=0x0000_0000, busy high for 3 cycles.
REQ-033 Store/load: store 0xDEADBEEF to 0x20 with be=4'hF, then load 0x20 -> rdata=0xDEADBEEF.
REQ-034 Partial store: store 0x000000AA to 0x20 with be=4'b0001, then load 0x20 -> rdata=0xDEADBEAA; a store with be=0 leaves the word unchanged.
REQ-035 Back-to-back: req held high for 4 loads with LATENCY=0 -> ack every 2nd cycle, 4 acks total; LATENCY=15 -> one ack every 17 cycles.
REQ-036 Reset mid-access: rst low during WAIT of a store to 0x30 -> no ack; a subsequent load of 0x30 returns the old contents.
REQ-037 Faults (DMEM_RESP_ERR_EN): load 0x22 -> err=1, rdata=0; store to DEPTH*4 -> err=1, memory unchanged. Without the macro, load 0x22 returns the word at 0x20.
